// File: rtl/proc_mem_responder.sv
// Memory-side responder: word-addressed RAM with same-cycle reads, clocked writes and a
// backdoor load port, plus an MMIO window with input/output FIFOs and a cycle counter.
module proc_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        imemreq_val,
  input  logic [31:0] imemreq_addr,
  output logic [31:0] imemresp_data,

  input  logic        dmemreq_val,
  input  logic        dmemreq_type,
  input  logic [31:0] dmemreq_addr,
  input  logic [31:0] dmemreq_wdata,
  output logic [31:0] dmemresp_rdata,

  input  logic        ld_val,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,

  input  logic        in_val,
  input  logic [31:0] in_data,
  output logic        in_rdy,

  output logic        out_val,
  output logic [31:0] out_data,
  input  logic        out_rdy,

  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned FW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = FW + 1;
  localparam logic [CW-1:0] FifoFull = CW'(FIFO_DEPTH);

  localparam logic [31:0] MmioInPop  = 32'h0002_0000;
  localparam logic [31:0] MmioInCnt  = 32'h0002_0004;
  localparam logic [31:0] MmioOutPsh = 32'h0002_0008;
  localparam logic [31:0] MmioCycle  = 32'h0002_000C;

  function automatic logic in_ram(input logic [31:0] a);
    return a[31:AW+2] == '0;
  endfunction

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0]   in_mem_q [FIFO_DEPTH];
  logic [FW-1:0] in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;

  logic [31:0]   out_mem_q [FIFO_DEPTH];
  logic [FW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;

  logic [31:0] cyc_q, cyc_d;
  logic        err_q, err_d;

  logic [AW-1:0] imem_idx, dmem_idx, ld_idx;
  logic          imem_err, dmem_err, ld_err, ld_we, ram_we;
  logic          in_empty, in_push, in_pop;
  logic          out_full, out_push, out_pop;

  assign imem_idx = imemreq_addr[AW+1:2];
  assign dmem_idx = dmemreq_addr[AW+1:2];
  assign ld_idx   = ld_addr[AW+1:2];

  assign in_empty = (in_cnt_q == '0);
  assign in_rdy   = (in_cnt_q != FifoFull);
  assign in_push  = in_val && in_rdy;

  assign out_full = (out_cnt_q == FifoFull);
  assign out_val  = (out_cnt_q != '0);
  // Storage is not reset, so the head is masked while empty.
  assign out_data = out_val ? out_mem_q[out_rd_q] : '0;
  assign out_pop  = out_val && out_rdy;

  assign err = err_q;

  // Instruction port: RAM only; MMIO and everything else is an error.
  always_comb begin
    imemresp_data = '0;
    imem_err      = 1'b0;
    if (imemreq_val) begin
      if (imemreq_addr[1:0] != 2'b00 || !in_ram(imemreq_addr)) begin
        imem_err = 1'b1;
      end else begin
        imemresp_data = mem_q[imem_idx];
      end
    end
  end

  // Data port decode: RAM, then the four MMIO words, anything else errors.
  always_comb begin
    dmemresp_rdata = '0;
    dmem_err       = 1'b0;
    ram_we         = 1'b0;
    in_pop         = 1'b0;
    out_push       = 1'b0;
    if (dmemreq_val) begin
      if (dmemreq_addr[1:0] != 2'b00) begin
        dmem_err = 1'b1;
      end else if (in_ram(dmemreq_addr)) begin
        if (dmemreq_type) begin
          ram_we = 1'b1;
        end else begin
          dmemresp_rdata = mem_q[dmem_idx];
        end
      end else begin
        case (dmemreq_addr)
          MmioInPop: begin
            if (dmemreq_type) begin
              dmem_err = 1'b1;
            end else if (!in_empty) begin
              dmemresp_rdata = in_mem_q[in_rd_q];
              in_pop         = 1'b1;
            end
          end
          MmioInCnt: begin
            if (dmemreq_type) dmem_err = 1'b1;
            else              dmemresp_rdata = 32'(in_cnt_q);
          end
          MmioOutPsh: begin
            if (!dmemreq_type || out_full) dmem_err = 1'b1;
            else                           out_push = 1'b1;
          end
          MmioCycle: begin
            if (dmemreq_type) dmem_err = 1'b1;
            else              dmemresp_rdata = cyc_q;
          end
          default: dmem_err = 1'b1;
        endcase
      end
    end
  end

  always_comb begin
    ld_we  = 1'b0;
    ld_err = 1'b0;
    if (ld_val) begin
      if (ld_addr[1:0] == 2'b00 && in_ram(ld_addr)) ld_we  = 1'b1;
      else                                          ld_err = 1'b1;
    end
  end

  // Backdoor write is issued last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[dmem_idx] <= dmemreq_wdata;
    if (ld_we)  mem_q[ld_idx]   <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (in_push)  in_mem_q[in_wr_q]   <= in_data;
    if (out_push) out_mem_q[out_wr_q] <= dmemreq_wdata;
  end

  always_comb begin
    in_wr_d  = in_push ? in_wr_q + 1'b1 : in_wr_q;
    in_rd_d  = in_pop  ? in_rd_q + 1'b1 : in_rd_q;
    in_cnt_d = in_cnt_q;
    unique case ({in_push, in_pop})
      2'b10:   in_cnt_d = in_cnt_q + 1'b1;
      2'b01:   in_cnt_d = in_cnt_q - 1'b1;
      default: in_cnt_d = in_cnt_q;
    endcase

    out_wr_d  = out_push ? out_wr_q + 1'b1 : out_wr_q;
    out_rd_d  = out_pop  ? out_rd_q + 1'b1 : out_rd_q;
    out_cnt_d = out_cnt_q;
    unique case ({out_push, out_pop})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase

    cyc_d = cyc_q + 32'd1;
    err_d = err_q | imem_err | dmem_err | ld_err;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_wr_q   <= '0;
      in_rd_q   <= '0;
      in_cnt_q  <= '0;
      out_wr_q  <= '0;
      out_rd_q  <= '0;
      out_cnt_q <= '0;
      cyc_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      in_wr_q   <= in_wr_d;
      in_rd_q   <= in_rd_d;
      in_cnt_q  <= in_cnt_d;
      out_wr_q  <= out_wr_d;
      out_rd_q  <= out_rd_d;
      out_cnt_q <= out_cnt_d;
      cyc_q     <= cyc_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_proc_mem_responder.sv
// Bench for proc_mem_responder: directed scenarios plus random traffic, all checked against a
// queue/array reference model of the memory, FIFOs, counter and error flag.
module tb_proc_mem_responder;

  localparam int DW = 256;
  localparam int FD = 8;
  localparam logic [31:0] RamBytes = 32'(DW * 4);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imemreq_val, dmemreq_val, dmemreq_type, ld_val, in_val, out_rdy;
  logic [31:0] imemreq_addr, dmemreq_addr, dmemreq_wdata, ld_addr, ld_data, in_data;
  logic [31:0] imemresp_data, dmemresp_rdata, out_data;
  logic        in_rdy, out_val, err;

  always #5 clk = ~clk;

  proc_mem_responder #(.DEPTH_WORDS(DW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .imemreq_val(imemreq_val), .imemreq_addr(imemreq_addr), .imemresp_data(imemresp_data),
    .dmemreq_val(dmemreq_val), .dmemreq_type(dmemreq_type), .dmemreq_addr(dmemreq_addr),
    .dmemreq_wdata(dmemreq_wdata), .dmemresp_rdata(dmemresp_rdata),
    .ld_val(ld_val), .ld_addr(ld_addr), .ld_data(ld_data),
    .in_val(in_val), .in_data(in_data), .in_rdy(in_rdy),
    .out_val(out_val), .out_data(out_data), .out_rdy(out_rdy),
    .err(err)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] mem_m [DW];
  logic [31:0] inq [$];
  logic [31:0] outq [$];
  logic [31:0] cyc_m;
  logic        err_m;
  logic [31:0] last_i, last_d, last_od;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    imemreq_val = 0; imemreq_addr = '0;
    dmemreq_val = 0; dmemreq_type = 0; dmemreq_addr = '0; dmemreq_wdata = '0;
    ld_val = 0; ld_addr = '0; ld_data = '0;
    in_val = 0; in_data = '0; out_rdy = 0;
  endtask

  task automatic rd_i(input logic [31:0] a);
    imemreq_val = 1; imemreq_addr = a;
  endtask

  task automatic rd_d(input logic [31:0] a);
    dmemreq_val = 1; dmemreq_type = 0; dmemreq_addr = a;
  endtask

  task automatic wr_d(input logic [31:0] a, input logic [31:0] d);
    dmemreq_val = 1; dmemreq_type = 1; dmemreq_addr = a; dmemreq_wdata = d;
  endtask

  // Called at a negedge with inputs driven; checks the cycle, advances the model, ends at negedge.
  task automatic run_cycle();
    logic [31:0] ei, ed, eod;
    logic        e, dwr, ldw, ipop, ipush, opush, opop;
    ei = '0; ed = '0; e = 0; dwr = 0; ldw = 0; ipop = 0; opush = 0;
    #1;
    if (imemreq_val) begin
      if (imemreq_addr[1:0] != 2'b00 || imemreq_addr >= RamBytes) e = 1;
      else ei = mem_m[imemreq_addr[9:2]];
    end
    if (dmemreq_val) begin
      if (dmemreq_addr[1:0] != 2'b00) e = 1;
      else if (dmemreq_addr < RamBytes) begin
        if (dmemreq_type) dwr = 1;
        else ed = mem_m[dmemreq_addr[9:2]];
      end else if (dmemreq_addr == 32'h0002_0000 && !dmemreq_type) begin
        if (inq.size() > 0) begin ed = inq[0]; ipop = 1; end
      end else if (dmemreq_addr == 32'h0002_0004 && !dmemreq_type) begin
        ed = 32'(inq.size());
      end else if (dmemreq_addr == 32'h0002_0008 && dmemreq_type) begin
        if (outq.size() < FD) opush = 1;
        else e = 1;
      end else if (dmemreq_addr == 32'h0002_000C && !dmemreq_type) begin
        ed = cyc_m;
      end else e = 1;
    end
    if (ld_val) begin
      if (ld_addr[1:0] == 2'b00 && ld_addr < RamBytes) ldw = 1;
      else e = 1;
    end
    ipush = in_val && (inq.size() < FD);
    opop  = out_rdy && (outq.size() > 0);
    eod   = (outq.size() > 0) ? outq[0] : '0;

    check("imem_data", imemresp_data, ei);
    check("dmem_data", dmemresp_rdata, ed);
    check("in_rdy", 32'(in_rdy), 32'(inq.size() < FD));
    check("out_val", 32'(out_val), 32'(outq.size() > 0));
    check("out_data", out_data, eod);
    check("err", 32'(err), 32'(err_m));
    last_i = imemresp_data; last_d = dmemresp_rdata; last_od = out_data;

    @(posedge clk);
    if (dwr) mem_m[dmemreq_addr[9:2]] = dmemreq_wdata;
    if (ldw) mem_m[ld_addr[9:2]] = ld_data;
    if (ipop) void'(inq.pop_front());
    if (ipush) inq.push_back(in_data);
    if (opop) void'(outq.pop_front());
    if (opush) outq.push_back(dmemreq_wdata);
    cyc_m = cyc_m + 32'd1;
    err_m = err_m | e;
    @(negedge clk);
  endtask

  // Entered at a negedge; holds reset across one rising edge, releases at the next negedge.
  task automatic do_reset();
    idle();
    rst = 0;
    #1;
    inq.delete(); outq.delete(); cyc_m = '0; err_m = 0;
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_out_val", 32'(out_val), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1;
  endtask

  function automatic logic [31:0] rand_addr(input int unsigned lo);
    logic [31:0] w;
    w = 32'($urandom_range(15, lo)) << 2;
    case ($urandom_range(9, 0))
      0, 1, 2, 3: return w;
      4: return w + 32'($urandom_range(3, 1));
      5: return 32'h0002_0000;
      6: return 32'h0002_0004;
      7: return 32'h0002_0008;
      8: return 32'h0002_000C;
      default: begin
        case ($urandom_range(3, 0))
          0: return RamBytes;
          1: return 32'h0002_0010;
          2: return 32'h0001_FFFC;
          default: return 32'hFFFF_FFFC;
        endcase
      end
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    cyc_m = '0; err_m = 0;
    @(negedge clk);
    do_reset();

    // Counter: read on cycle n after reset returns n.
    repeat (3) run_cycle();
    rd_d(32'h0002_000C); run_cycle(); idle();
    check("cycle_n", last_d, 32'd3);

    // Preload words 0..15.
    for (int i = 0; i < 16; i++) begin
      ld_val = 1; ld_addr = 32'(i) << 2;
      ld_data = (i == 0) ? 32'h0000_0013 : (i == 1) ? 32'hDEAD_BEEF : $urandom;
      run_cycle();
    end
    idle();
    rd_i(32'h4); run_cycle(); idle();
    check("fetch_4", last_i, 32'hDEAD_BEEF);
    check("fetch_err", 32'(err), 32'd0);

    // Read-during-write on word 4.
    wr_d(32'h10, 32'h1234_5678); rd_i(32'h10); run_cycle(); idle();
    rd_i(32'h10); run_cycle(); idle();
    check("rdw_new", last_i, 32'h1234_5678);

    // Input FIFO.
    in_val = 1; in_data = 32'd5; run_cycle();
    in_data = 32'd7; run_cycle(); idle();
    rd_d(32'h0002_0004); run_cycle();
    check("in_count", last_d, 32'd2);
    rd_d(32'h0002_0000); run_cycle(); check("in_pop5", last_d, 32'd5);
    run_cycle(); check("in_pop7", last_d, 32'd7);
    run_cycle(); check("in_pop_empty", last_d, 32'd0);
    idle();
    check("in_empty_err", 32'(err), 32'd0);
    for (int i = 0; i < FD; i++) begin
      in_val = 1; in_data = $urandom; run_cycle();
    end
    idle();
    check("in_full_rdy", 32'(in_rdy), 32'd0);
    rd_d(32'h0002_0000); in_val = 1; in_data = 32'hAAAA_0001; run_cycle(); idle();
    for (int i = 0; i < FD; i++) begin rd_d(32'h0002_0000); run_cycle(); end
    idle();

    // Output FIFO overflow.
    for (int k = 1; k <= 9; k++) begin wr_d(32'h0002_0008, 32'(k)); run_cycle(); end
    idle();
    check("ovf_err", 32'(err), 32'd1);
    out_rdy = 1;
    for (int k = 1; k <= 8; k++) begin
      run_cycle();
      check("ovf_pop", last_od, 32'(k));
    end
    idle();
    check("ovf_drained", 32'(out_val), 32'd0);

    // Error cases.
    do_reset();
    rd_i(32'h0002_0000); run_cycle(); idle();
    check("imem_mmio_data", last_i, 32'd0);
    check("imem_mmio_err", 32'(err), 32'd1);
    wr_d(32'h2, 32'hFFFF_FFFF); run_cycle(); idle();
    rd_d(32'h0); run_cycle(); idle();
    check("misaligned_wr", last_d, 32'h0000_0013);
    repeat (3) run_cycle();
    check("err_sticky", 32'(err), 32'd1);
    do_reset();
    check("err_cleared", 32'(err), 32'd0);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      idle();
      imemreq_val = ($urandom_range(1, 0) == 1);
      imemreq_addr = rand_addr(0);
      dmemreq_val = ($urandom_range(3, 0) != 0);
      dmemreq_type = ($urandom_range(1, 0) == 1);
      dmemreq_addr = rand_addr(2);
      dmemreq_wdata = $urandom;
      ld_val = ($urandom_range(3, 0) == 0);
      ld_addr = ($urandom_range(3, 0) == 0) ? rand_addr(2) + 32'd1 : 32'($urandom_range(15, 2)) << 2;
      ld_data = $urandom;
      in_val = ($urandom_range(1, 0) == 1);
      in_data = $urandom;
      out_rdy = ($urandom_range(1, 0) == 1);
      run_cycle();
    end
    idle();

    // Fill both FIFOs a little, then assert reset with no clock edge.
    for (int i = 0; i < 3; i++) begin
      in_val = 1; in_data = $urandom; wr_d(32'h0002_0008, $urandom); run_cycle();
    end
    idle();
    rst = 0;
    rd_i(32'h4); rd_d(32'h0002_000C);
    #1;
    check("mid_rst_ram", imemresp_data, 32'hDEAD_BEEF);
    check("mid_rst_cycle", dmemresp_rdata, 32'd0);
    check("mid_rst_in_rdy", 32'(in_rdy), 32'd1);
    check("mid_rst_out_val", 32'(out_val), 32'd0);
    check("mid_rst_out_data", out_data, 32'd0);
    inq.delete(); outq.delete(); cyc_m = '0; err_m = 0;
    @(negedge clk);
    idle();
    rst = 1;
    rd_d(32'h0002_0004); run_cycle();
    check("post_rst_count", last_d, 32'd0);
    idle();
    run_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
